// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file for the rv32 core.
//   Executes CSRRW/CSRRS/CSRRC accesses from execute, records trap state
//   (mepc/mcause/mtval and the MIE/MPIE stack), handles mret, produces the
//   registered fetch redirect and the gated machine interrupt request.
//   Optional feature macro: CSR_COUNTERS_EN (64-bit mcycle/minstret).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pc                       PC of the instruction in execute
//   csr_valid/op/addr/wdata  CSR access request (op 01 RW, 10 RS, 11 RC)
//   csr_rdata, csr_illegal   old CSR value / access fault (combinational)
//   trap_valid/irq/code/tval trap entry request
//   mret, retire             mret and instruction-retire strobes
//   irq_ext/timer/sw         level interrupt lines; irq_take = gated request
//   redirect_valid/pc        one-cycle registered fetch redirect
module csr_file #(
    parameter int unsigned XLEN        = 32,
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    input  logic            csr_valid,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap_valid,
    input  logic            trap_irq,
    input  logic [4:0]      trap_code,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret,
    input  logic            retire,
    input  logic            irq_ext,
    input  logic            irq_timer,
    input  logic            irq_sw,
    output logic            irq_take,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    csr_op_e         op;
    logic            st_mie, st_mpie;
    logic [2:0]      mie_bits;        // {MEIE, MTIE, MSIE}
    logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, mtval;
    logic [XLEN-1:0] mstatus_view, mie_view, mip_view;
    logic [XLEN-1:0] rval, wval, trap_base, trap_target;
    logic            known, csr_we;

    assign op = csr_op_e'(csr_op);

    assign mstatus_view = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
    assign mie_view     = {20'b0, mie_bits[2], 3'b0, mie_bits[1], 3'b0, mie_bits[0], 3'b0};
    assign mip_view     = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};

`ifdef CSR_COUNTERS_EN
    logic [XLEN-1:0] mcycle_lo, mcycle_hi, minstret_lo, minstret_hi;
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

    always_comb begin
        known = 1'b1;
        rval  = '0;
        case (csr_addr)
            12'h300: rval = mstatus_view;
            12'h301: rval = 32'h4000_0100;
            12'h304: rval = mie_view;
            12'h305: rval = mtvec;
            12'h340: rval = mscratch;
            12'h341: rval = mepc;
            12'h342: rval = mcause;
            12'h343: rval = mtval;
            12'h344: rval = mip_view;
`ifdef CSR_COUNTERS_EN
            12'hB00: rval = mcycle_lo;
            12'hB80: rval = mcycle_hi;
            12'hB02: rval = minstret_lo;
            12'hB82: rval = minstret_hi;
`else
            12'hB00, 12'hB80, 12'hB02, 12'hB82: rval = '0;
`endif
            12'hF14: rval = HART_ID;
            default: known = 1'b0;
        endcase
    end

    // Read-only address space (addr[11:10] == 11) faults on any access that
    // would write: RW always, RS/RC only with a nonzero mask.
    assign csr_illegal = csr_valid && (op != OP_NONE) &&
                         (!known || (csr_addr[11:10] == 2'b11 &&
                                     (op == OP_RW || (|csr_wdata))));
    assign csr_rdata   = csr_illegal ? '0 : rval;

    always_comb begin
        case (op)
            OP_RW:   wval = csr_wdata;
            OP_RS:   wval = rval | csr_wdata;
            OP_RC:   wval = rval & ~csr_wdata;
            default: wval = rval;
        endcase
    end

    // RS/RC with a zero mask never write; traps and mret drop the write.
    assign csr_we = csr_valid && (op != OP_NONE) && !csr_illegal &&
                    (op == OP_RW || (|csr_wdata)) && !trap_valid && !mret;

    assign trap_base   = mtvec & ~(XLEN'(3));
    assign trap_target = (mtvec[1:0] == 2'b01 && trap_irq)
                       ? trap_base + {{(XLEN-7){1'b0}}, trap_code, 2'b00}
                       : trap_base;

    assign irq_take = st_mie && (|(mie_bits & {irq_ext, irq_timer, irq_sw}));

    always_ff @(posedge clk) begin
        if (rst) begin
            st_mie         <= 1'b0;
            st_mpie        <= 1'b0;
            mie_bits       <= '0;
            mtvec          <= MTVEC_RESET;
            mscratch       <= '0;
            mepc           <= '0;
            mcause         <= '0;
            mtval          <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= trap_valid || mret;
            if (trap_valid) begin
                mepc        <= pc & ~(XLEN'(3));
                mcause      <= {trap_irq, {(XLEN-6){1'b0}}, trap_code};
                mtval       <= trap_tval;
                st_mpie     <= st_mie;
                st_mie      <= 1'b0;
                redirect_pc <= trap_target;
            end else if (mret) begin
                st_mie      <= st_mpie;
                st_mpie     <= 1'b1;
                redirect_pc <= mepc;
            end else if (csr_we) begin
                case (csr_addr)
                    12'h300: begin
                        st_mie  <= wval[3];
                        st_mpie <= wval[7];
                    end
                    12'h304: mie_bits <= {wval[11], wval[7], wval[3]};
                    12'h305: mtvec    <= wval;
                    12'h340: mscratch <= wval;
                    12'h341: mepc     <= wval & ~(XLEN'(3));
                    12'h342: mcause   <= wval;
                    12'h343: mtval    <= wval;
                    default: ;
                endcase
            end
        end
    end

`ifdef CSR_COUNTERS_EN
    logic wr_cyc_lo, wr_cyc_hi, wr_ins_lo, wr_ins_hi;
    assign wr_cyc_lo = csr_we && csr_addr == 12'hB00;
    assign wr_cyc_hi = csr_we && csr_addr == 12'hB80;
    assign wr_ins_lo = csr_we && csr_addr == 12'hB02;
    assign wr_ins_hi = csr_we && csr_addr == 12'hB82;

    // A write to a half replaces that half's increment; a written low half
    // does not carry into the high half.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle_lo   <= '0;
            mcycle_hi   <= '0;
            minstret_lo <= '0;
            minstret_hi <= '0;
        end else begin
            mcycle_lo <= wr_cyc_lo ? wval : mcycle_lo + 1'b1;
            if (wr_cyc_hi)
                mcycle_hi <= wval;
            else if (!wr_cyc_lo && (&mcycle_lo))
                mcycle_hi <= mcycle_hi + 1'b1;

            if (wr_ins_lo)
                minstret_lo <= wval;
            else if (retire)
                minstret_lo <= minstret_lo + 1'b1;
            if (wr_ins_hi)
                minstret_hi <= wval;
            else if (retire && !wr_ins_lo && (&minstret_lo))
                minstret_hi <= minstret_hi + 1'b1;
        end
    end
`endif

endmodule
